// File: rtl/sn74xx194.sv
// Parameterised 74xx194-style universal shift register: hold, shift right, shift left, parallel load.
// Optional shift counter (cnt/full) is built only when SN74XX194_CNT_EN is defined.
module sn74xx194 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             dsr,
  input  logic             dsl,
  output logic [WIDTH-1:0] q,
  output logic             sor,
  output logic             sol
`ifdef SN74XX194_CNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       full
`endif
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // An X/Z mode has no matching item and poisons the register so illegal stimulus stays visible.
  always_comb begin
    shreg_d = shreg_q;
    case (mode)
      MODE_HOLD: shreg_d = shreg_q;
      MODE_SHR:  shreg_d = {shreg_q[WIDTH-2:0], dsr};
      MODE_SHL:  shreg_d = {dsl, shreg_q[WIDTH-1:1]};
      MODE_LOAD: shreg_d = d;
      default:   shreg_d = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q   = shreg_q;
  assign sor = shreg_q[WIDTH-1];
  assign sol = shreg_q[0];

`ifdef SN74XX194_CNT_EN
  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Either shift direction counts one bit leaving the register; the count saturates at WIDTH.
  always_comb begin
    cnt_d = cnt_q;
    case (mode)
      MODE_HOLD: cnt_d = cnt_q;
      MODE_SHR,
      MODE_SHL:  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      MODE_LOAD: cnt_d = '0;
      default:   cnt_d = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_MAX);
`endif

endmodule

// File: tb/tb_sn74xx194.sv
// Directed bench for sn74xx194 (WIDTH=4): reset, load, shifts, hold, saturation, async reset.
module tb_sn74xx194;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             dsr;
  logic             dsl;
  logic [WIDTH-1:0] q;
  logic             sor;
  logic             sol;
`ifdef SN74XX194_CNT_EN
  logic [$clog2(WIDTH+1)-1:0] cnt;
  logic                       full;
`endif

  int tests_run;
  int tests_failed;

  sn74xx194 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .d    (d),
    .dsr  (dsr),
    .dsl  (dsl),
    .q    (q),
    .sor  (sor),
    .sol  (sol)
`ifdef SN74XX194_CNT_EN
    ,
    .cnt  (cnt),
    .full (full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Sample 1ns after the rising edge, then inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [WIDTH-1:0] exp_q);
    chk({tag, ".q"},   8'(q),   8'(exp_q));
    chk({tag, ".sor"}, 8'(sor), 8'(exp_q[WIDTH-1]));
    chk({tag, ".sol"}, 8'(sol), 8'(exp_q[0]));
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp_cnt, input logic exp_full);
`ifdef SN74XX194_CNT_EN
    chk({tag, ".cnt"},  8'(cnt),  exp_cnt);
    chk({tag, ".full"}, 8'(full), 8'(exp_full));
`else
    if (exp_cnt > 8'd4 || exp_full === 1'bx) $display("[TB] note %s", tag);
`endif
  endtask

  logic [WIDTH-1:0] shr_exp [4];
  logic [WIDTH-1:0] shl_exp [6];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst  = 1'b0;
    mode = 2'b00;
    d    = '0;
    dsr  = 1'b0;
    dsl  = 1'b0;
    shr_exp = '{4'b0101, 4'b1011, 4'b0111, 4'b1111};
    shl_exp = '{4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b1111, 4'b1111};

    // 1. Reset asserted between edges takes effect immediately, then load 1010.
    #2 rst = 1'b1;
    #1;
    chk_q("rst_async", 4'b0000);
    chk_cnt("rst_async", 8'd0, 1'b0);
    #4 rst = 1'b0;
    mode = 2'b11;
    d    = 4'b1010;
    step();
    chk_q("load_1010", 4'b1010);
    chk_cnt("load_1010", 8'd0, 1'b0);

    // 2. Shift right with dsr=1.
    mode = 2'b01;
    dsr  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_q($sformatf("shr%0d", i + 1), shr_exp[i]);
      chk_cnt($sformatf("shr%0d", i + 1), 8'(i + 1), (i == 3));
    end

    // 3. Load 1111, shift left with dsl=0, then hold.
    mode = 2'b11;
    d    = 4'b1111;
    step();
    chk_q("load_1111", 4'b1111);
    chk_cnt("load_1111", 8'd0, 1'b0);
    mode = 2'b10;
    dsl  = 1'b0;
    step();
    chk_q("shl1", 4'b0111);
    chk_cnt("shl1", 8'd1, 1'b0);
    step();
    chk_q("shl2", 4'b0011);
    chk_cnt("shl2", 8'd2, 1'b0);
    mode = 2'b00;
    dsl  = 1'b1;
    dsr  = 1'b1;
    d    = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_q($sformatf("hold%0d", i + 1), 4'b0011);
      chk_cnt($sformatf("hold%0d", i + 1), 8'd2, 1'b0);
    end

    // 4. Load 0110, six left shifts with dsl=1 (saturation), then reload 0101.
    mode = 2'b11;
    d    = 4'b0110;
    step();
    chk_q("load_0110", 4'b0110);
    mode = 2'b10;
    dsl  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_q($sformatf("sat%0d", i + 1), shl_exp[i]);
      chk_cnt($sformatf("sat%0d", i + 1), 8'((i < 3) ? i + 1 : 4), (i >= 3));
    end
    mode = 2'b11;
    d    = 4'b0101;
    step();
    chk_q("reload_0101", 4'b0101);
    chk_cnt("reload_0101", 8'd0, 1'b0);

    // 5. Async reset mid-shift, then release coincident with a rising edge.
    d    = 4'b1010;
    step();
    mode = 2'b01;
    dsr  = 1'b1;
    step();
    step();
    chk_q("pre_rst", 4'b1011);
    chk_cnt("pre_rst", 8'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_q("mid_rst", 4'b0000);
    chk_cnt("mid_rst", 8'd0, 1'b0);
    dsr = 1'b0;
    @(posedge clk);
    chk_q("rst_held_edge", 4'b0000);
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk_q("rst_release_edge", 4'b0000);
    dsr = 1'b1;
    step();
    chk_q("post_rst_shr", 4'b0001);
    mode = 2'b11;
    d    = 4'b1100;
    step();
    chk_q("post_rst_load", 4'b1100);
    chk_cnt("post_rst_load", 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
